imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Byte-stream writer feeding the SingleCycleClockMIPS instruction-write port (W_Ins/WE).
// - Takes a length-prefixed program image from a byte source (UART RX, JTAG FIFO, bench BFM) and assembles 32-bit words.
// - Drives W_Ins/WE and holds the CPU in reset until the full image is written.
// - Sits between the host byte link and the CPU top; the CPU sees its normal W_Ins/WE write interface.
// PARAMETERS
// - DEPTH   256  instruction memory depth in words; max accepted image length
// - ADDR_W  8    width of W_Addr/word_count; must satisfy 2**ADDR_W >= DEPTH
// PORTS
// - CLK         in   1       system clock, all logic on rising edge
// - RST         in   1       synchronous, active-high reset
// - start       in   1       pulse: begin a load; sampled only in IDLE or DONE
// - byte_in     in   8       incoming stream byte
// - byte_valid  in   1       byte_in valid
// - byte_ready  out  1       loader accepts byte_in this cycle
// - W_Ins       out  32      instruction word to CPU imem
// - WE          out  1       one-cycle write strobe for W_Ins
// - W_Addr      out  ADDR_W  word index of the current write (0-based)
// - cpu_rst     out  1       CPU reset request, OR'd into the CPU's RST
// - busy        out  1       load in progress
// - done        out  1       image fully written; CPU released
// - err         out  1       load aborted (bad length / checksum)
// BEHAVIOUR
// - Reset values: byte_ready=0, W_Ins=0, WE=0, W_Addr=0, cpu_rst=1, busy=0, done=0, err=0; FSM->IDLE.
// - Byte transfer happens on a cycle with byte_valid && byte_ready. byte_ready is combinational from state only (HDR_HI, HDR_LO, DATA, CSUM).
// - FSM: IDLE -start-> HDR_HI -byte-> HDR_LO -byte-> DATA/DONE/ERR; DATA -last byte-> CSUM (macro) or DONE.
//   - CSUM -byte-> DONE or ERR. DONE -start-> HDR_HI. ERR -start-> HDR_HI.
// - Header: 16-bit word count N, big-endian (first byte = N[15:8]).
//   - N==0: -> DONE with no writes.
//   - N>DEPTH: -> ERR, no writes, payload not consumed.
// - Data: bytes are big-endian within each word; byte 0 goes to W_Ins[31:24] (MIPS byte order).
// - On acceptance of the 4th byte of word k:
//   - Next cycle: W_Ins=word, W_Addr=k, WE=1 for exactly one cycle.
//   - Latency is 1 cycle from the 4th byte handshake to WE.
// - W_Ins/W_Addr hold their last values after WE drops.
// - Back-to-back bytes are accepted with no stalls: max rate 1 byte/cycle, so WE fires at most every 4th cycle.
// - Word counter wraps never: the FSM leaves DATA after word N-1. W_Addr max = N-1.
// - cpu_rst=1 in every state except DONE; it drops in the cycle DONE is entered.
//   - start in DONE re-asserts cpu_rst in the next cycle (reload).
// - busy=1 in HDR_HI/HDR_LO/DATA/CSUM. done=1 only in DONE. err=1 only in ERR.
// - start while busy: ignored. byte_valid in IDLE/DONE/ERR: ignored, byte_ready=0.
// - Simultaneous start and RST: RST wins.
// - RST mid-load: all outputs return to their reset values on the next edge. WE is never asserted in the cycle after RST.
//   - Partially written imem contents are left as-is.
// CONFIGURATION
// - Macro IMEM_LOADER_CSUM_EN:
//   - Defined: after the last data byte, one extra byte is expected. It must equal the XOR of all 4N data bytes (0x00 when N==0, still sent).
//     - Match -> DONE. Mismatch -> ERR; cpu_rst stays 1; words already written are not rolled back.
//   - Undefined: no CSUM state. The last data byte -> DONE. err only flags N>DEPTH.
// TESTING
// - RST=1 for 2 cycles -> cpu_rst=1, WE=0, byte_ready=0. start, stream 00 02 | 3C 10 00 0A | 02 11 48 20 at 1 byte/cycle -> WE pulses with W_Ins=0x3C10000A at W_Addr=0, then 0x02114820 at W_Addr=1 -> done=1, cpu_rst=0.
// - Same image with byte_valid toggling 1/0 every cycle -> identical writes; each WE is 1 cycle after its 4th accepted byte.
// - Header 01 01 (257) with DEPTH=256 -> err=1, zero WE pulses, cpu_rst=1. Header 00 00 -> done=1, zero WE pulses (macro defined: after the CSUM byte 0x00).
// - RST asserted after 6 data bytes -> next cycle all outputs at reset values. A fresh load of N=1 then writes W_Addr=0 correctly.
// - IMEM_LOADER_CSUM_EN defined, N=1, data 12 34 56 78, CSUM 0x08 -> done=1; CSUM 0x09 -> err=1 and cpu_rst=1 (WE still fired once).
// - In DONE, start pulse -> cpu_rst=1 next cycle and busy=1. start pulsed mid-DATA -> no effect on the FSM or W_Addr.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream to 32-bit imem write port loader; IMEM_LOADER_CSUM_EN adds trailing XOR checksum byte
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [31:0]       W_Ins,
    output logic              WE,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
`ifdef IMEM_LOADER_CSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    // State entered once the payload (possibly empty) has been consumed
`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t TAIL = CSUM;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t            state, state_n;
    logic              fire;
    logic [7:0]        hdr_hi;
    logic [15:0]       hdr_n;
    logic [15:0]       n_words;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       shift;
    logic              word_last;
    logic              too_big;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        csum;
`endif

    assign fire      = byte_valid && byte_ready;
    assign hdr_n     = {hdr_hi, byte_in};
    assign too_big   = ({1'b0, hdr_n} > 17'(DEPTH));
    assign word_last = (16'(word_idx) == (n_words - 16'd1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst    = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_n = HDR_HI;
            end
            HDR_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_n = HDR_LO;
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if (hdr_n == 16'd0)  state_n = TAIL;
                    else if (too_big)    state_n = ERR;
                    else                 state_n = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_idx == 2'd3 && word_last) state_n = TAIL;
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_n = (byte_in == csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) state_n = HDR_HI;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_n = HDR_HI;
            end
            default: state_n = IDLE;
        endcase
    end

    // Bytes shift in MSB-first; the 4th byte completes the word and fires WE next cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            W_Ins    <= 32'd0;
            WE       <= 1'b0;
            W_Addr   <= '0;
            hdr_hi   <= 8'd0;
            n_words  <= 16'd0;
            byte_idx <= 2'd0;
            word_idx <= '0;
            shift    <= 24'd0;
`ifdef IMEM_LOADER_CSUM_EN
            csum     <= 8'd0;
`endif
        end else begin
            WE <= 1'b0;
            if (fire) begin
                case (state)
                    HDR_HI: hdr_hi <= byte_in;
                    HDR_LO: begin
                        n_words  <= hdr_n;
                        byte_idx <= 2'd0;
                        word_idx <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum     <= 8'd0;
`endif
                    end
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        csum     <= csum ^ byte_in;
`endif
                        if (byte_idx == 2'd3) begin
                            W_Ins    <= {shift, byte_in};
                            W_Addr   <= word_idx;
                            WE       <= 1'b1;
                            word_idx <= word_idx + ADDR_W'(1);
                        end else begin
                            shift <= {shift[15:0], byte_in};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed table-driven bench for imem_loader (covers IMEM_LOADER_CSUM_EN builds too)
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] W_Ins;
    logic        WE;
    logic [7:0]  W_Addr;
    logic        cpu_rst, busy, done, err;

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .W_Ins(W_Ins),
        .WE(WE), .W_Addr(W_Addr), .cpu_rst(cpu_rst), .busy(busy),
        .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        st;
        logic        vld;
        logic [7:0]  d;
        logic [45:0] exp;
    } vec_t;

    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] wr_data[$];
    int          wr_addr[$];
    int          wr_cyc[$];
    logic [7:0]  img[$];
    int          acc[$];

    wire [45:0] obs = {byte_ready, WE, W_Ins, W_Addr, cpu_rst, busy, done, err};

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            wr_data.push_back(W_Ins);
            wr_addr.push_back(int'(W_Addr));
            wr_cyc.push_back(cyc);
        end
    end

    function automatic logic [45:0] pk(input logic rdy, input logic we, input logic [31:0] ins,
                                       input logic [7:0] addr, input logic cr, input logic bsy,
                                       input logic dn, input logic er);
        return {rdy, we, ins, addr, cr, bsy, dn, er};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic v, input logic [7:0] d,
                       input logic [45:0] e);
        vec_t t;
        t.rst = r; t.st = s; t.vld = v; t.d = d; t.exp = e;
        tbl.push_back(t);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge
    task automatic put_byte(input logic [7:0] b);
        int guard = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        while (byte_ready !== 1'b1 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 20) check("byte_ready_timeout", 64'(guard), 64'(0));
        acc.push_back(cyc);
        @(negedge CLK);
        byte_valid = 1'b0;
    endtask

    // Sends img; under the checksum build appends XOR of payload, flipped by csum_flip
    task automatic send_img(input int gap, input logic [7:0] csum_flip);
        logic [7:0] x;
        x = 8'd0;
        acc.delete();
        for (int i = 0; i < img.size(); i++) begin
            if (i >= 2) x = x ^ img[i];
            put_byte(img[i]);
            repeat (gap) @(negedge CLK);
        end
`ifdef IMEM_LOADER_CSUM_EN
        put_byte(x ^ csum_flip);
`else
        if (csum_flip != 8'd0) x = 8'd0;
`endif
    endtask

    initial begin
        logic [45:0] rv, hdr, dn;
        logic [31:0] w1, w2;
        logic [7:0]  bb;
        int base, bad, gaps;

        rv  = pk(0, 0, 32'h0, 8'h0, 1, 0, 0, 0);
        hdr = pk(1, 0, 32'h0, 8'h0, 1, 1, 0, 0);
        w1  = 32'h3C10000A;
        w2  = 32'h02114820;
        dn  = pk(0, 0, w2, 8'h1, 0, 0, 1, 0);

        add(1, 0, 0, 8'h00, rv);
        add(1, 0, 0, 8'h00, rv);
        add(0, 0, 1, 8'hFF, rv);
        add(0, 1, 0, 8'h00, hdr);
        add(0, 0, 1, 8'h00, hdr);
        add(0, 0, 1, 8'h02, hdr);
        add(0, 0, 1, 8'h3C, hdr);
        add(0, 0, 1, 8'h10, hdr);
        add(0, 0, 1, 8'h00, hdr);
        add(0, 0, 1, 8'h0A, pk(1, 1, w1, 8'h0, 1, 1, 0, 0));
        add(0, 0, 1, 8'h02, pk(1, 0, w1, 8'h0, 1, 1, 0, 0));
        add(0, 0, 1, 8'h11, pk(1, 0, w1, 8'h0, 1, 1, 0, 0));
        add(0, 0, 1, 8'h48, pk(1, 0, w1, 8'h0, 1, 1, 0, 0));
`ifdef IMEM_LOADER_CSUM_EN
        add(0, 0, 1, 8'h20, pk(1, 1, w2, 8'h1, 1, 1, 0, 0));
        add(0, 0, 1, 8'h5D, dn);
`else
        add(0, 0, 1, 8'h20, pk(0, 1, w2, 8'h1, 0, 0, 1, 0));
`endif
        add(0, 0, 1, 8'hFF, dn);
        add(0, 1, 0, 8'h00, pk(1, 0, w2, 8'h1, 1, 1, 0, 0));
        add(0, 0, 1, 8'h01, pk(1, 0, w2, 8'h1, 1, 1, 0, 0));
        add(0, 0, 1, 8'h01, pk(0, 0, w2, 8'h1, 1, 0, 0, 1));
        add(0, 0, 1, 8'h00, pk(0, 0, w2, 8'h1, 1, 0, 0, 1));
        add(0, 1, 0, 8'h00, pk(1, 0, w2, 8'h1, 1, 1, 0, 0));
        add(0, 0, 1, 8'h00, pk(1, 0, w2, 8'h1, 1, 1, 0, 0));
`ifdef IMEM_LOADER_CSUM_EN
        add(0, 0, 1, 8'h00, pk(1, 0, w2, 8'h1, 1, 1, 0, 0));
`endif
        add(0, 0, 1, 8'h00, dn);
        add(1, 1, 0, 8'h00, rv);
        add(0, 0, 1, 8'h55, rv);

        foreach (tbl[i]) begin
            RST        = tbl[i].rst;
            start      = tbl[i].st;
            byte_valid = tbl[i].vld;
            byte_in    = tbl[i].d;
            @(negedge CLK);
            check($sformatf("vec%0d", i), 64'(obs), 64'(tbl[i].exp));
        end
        RST = 1'b0; start = 1'b0; byte_valid = 1'b0;
        check("table_we_count", 64'(wr_data.size()), 64'(2));

        // Throttled stream: identical writes, WE exactly one cycle after each 4th byte
        base = wr_data.size();
        pulse_start();
        img = '{8'h00, 8'h02, 8'h3C, 8'h10, 8'h00, 8'h0A, 8'h02, 8'h11, 8'h48, 8'h20};
        send_img(1, 8'h00);
        @(negedge CLK);
        check("toggle_count", 64'(wr_data.size() - base), 64'(2));
        if (wr_data.size() - base == 2) begin
            check("toggle_w0", {wr_data[base], 32'(wr_addr[base])}, {w1, 32'd0});
            check("toggle_w1", {wr_data[base+1], 32'(wr_addr[base+1])}, {w2, 32'd1});
            check("toggle_lat0", 64'(wr_cyc[base]), 64'(acc[5] + 1));
            check("toggle_lat1", 64'(wr_cyc[base+1]), 64'(acc[9] + 1));
        end
        check("toggle_done", {done, cpu_rst, busy}, 3'b100);

        // Reset lands on the cycle that would have completed word 1
        pulse_start();
        img = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3};
        acc.delete();
        foreach (img[i]) put_byte(img[i]);
        base = wr_data.size();
        RST = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hB4;
        @(negedge CLK);
        check("midload_rst", 64'(obs), 64'(rv));
        RST = 1'b0; start = 1'b0; byte_valid = 1'b0;
        @(negedge CLK);
        check("rst_no_we", 64'(wr_data.size() - base), 64'(0));
        pulse_start();
        img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_img(0, 8'h00);
        @(negedge CLK);
        check("reload_count", 64'(wr_data.size() - base), 64'(1));
        if (wr_data.size() - base == 1)
            check("reload_w0", {wr_data[base], 32'(wr_addr[base])}, {32'h11223344, 32'd0});
        check("reload_done", {done, cpu_rst, err}, 3'b100);

        // start pulsed mid-DATA is ignored
        pulse_start();
        check("reload_cpu_rst", {cpu_rst, busy, done}, 3'b110);
        base = wr_data.size();
        img = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        acc.delete();
        for (int i = 0; i < img.size(); i++) begin
            start = (i == 4 || i == 7);
            put_byte(img[i]);
        end
        start = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        put_byte(8'h08);
`endif
        @(negedge CLK);
        check("busy_start_count", 64'(wr_data.size() - base), 64'(2));
        if (wr_data.size() - base == 2) begin
            check("busy_start_w0", {wr_data[base], 32'(wr_addr[base])}, {32'h01020304, 32'd0});
            check("busy_start_w1", {wr_data[base+1], 32'(wr_addr[base+1])}, {32'h05060708, 32'd1});
        end
        check("busy_start_done", {done, busy}, 2'b10);

`ifdef IMEM_LOADER_CSUM_EN
        base = wr_data.size();
        pulse_start();
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        acc.delete();
        foreach (img[i]) put_byte(img[i]);
        put_byte(8'h08);
        check("csum_ok", {done, err, cpu_rst}, 3'b100);
        pulse_start();
        acc.delete();
        foreach (img[i]) put_byte(img[i]);
        put_byte(8'h09);
        check("csum_bad", {done, err, cpu_rst}, 3'b011);
        check("csum_we_count", 64'(wr_data.size() - base), 64'(2));
`endif

        // Full-depth image at one byte per cycle
        base = wr_data.size();
        pulse_start();
        img.delete();
        img.push_back(8'h01);
        img.push_back(8'h00);
        for (int j = 0; j < 1024; j++) begin
            bb = 8'((j * 7 + 3) & 255);
            img.push_back(bb);
        end
        send_img(0, 8'h00);
        @(negedge CLK);
        check("max_count", 64'(wr_data.size() - base), 64'(256));
        bad = 0;
        gaps = 0;
        for (int k = 0; k < 256 && base + k < wr_data.size(); k++) begin
            if (wr_addr[base+k] != k ||
                wr_data[base+k] !== {img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]})
                bad++;
            if (k > 0 && wr_cyc[base+k] - wr_cyc[base+k-1] != 4) gaps++;
        end
        check("max_words_wrong", 64'(bad), 64'(0));
        check("max_we_spacing", 64'(gaps), 64'(0));
        check("max_done", {done, err, cpu_rst, byte_ready, W_Addr}, {4'b1000, 8'hFF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
